// File: rtl/bits4_link_pkg.sv
// Shared definitions for the single-wire shift-register link.
package bits4_link_pkg;

   // Serializer FSM states, encoded explicitly for legacy compatibility.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Line level driven while no frame is in progress.
   localparam logic IDLE_LEVEL_DEF = 1'b0;

   // Ceiling log2; returns at least 1 so a counter never collapses to zero width.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bits4_bit_counter.sv
// Bit counter with synchronous clear, increment and terminal-count flag.
module bits4_bit_counter
   import bits4_link_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   localparam int unsigned CNT_W = clog2(WIDTH)
) (
   input  logic             i_CLK,
   input  logic             i_RSTn,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_term_c
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   // Count register; clear wins over increment.
   always_ff @(posedge i_CLK) begin
      if (!i_RSTn) begin
         o_cnt <= '0;
      end else if (i_clr) begin
         o_cnt <= '0;
      end else if (i_inc) begin
         o_cnt <= o_cnt + CNT_W'(1);
      end
   end

   // Terminal flag: the last bit of the frame is on the line.
   assign o_term_c = (o_cnt == LAST);

endmodule

// File: rtl/bits4_serializer.sv
// Parallel-in/serial-out transmitter, LSB first, valid/ready word input.
module bits4_serializer
   import bits4_link_pkg::*;
#(
   parameter int unsigned WIDTH      = 4,
   parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEF
) (
   input  logic             i_CLK,
   input  logic             i_RSTn,
   input  logic [WIDTH-1:0] i_DATA,
   input  logic             i_VALID,
   output logic             o_READY,
   output logic             o_D,
   output logic             o_SVALID,
   output logic             o_BUSY,
   output logic             o_DONE
);

   localparam int unsigned CNT_W = clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_sh;

   state_t           w_state_nx;
   logic [WIDTH-1:0] w_sh_nx;
   logic             w_d_nx;
   logic             w_svalid_nx;
   logic             w_done_nx;
   logic             w_clr;
   logic             w_inc;
   logic             w_accept;
   logic             w_term;
   logic [CNT_W-1:0] w_cnt;

   bits4_bit_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .i_CLK    (i_CLK),
      .i_RSTn   (i_RSTn),
      .i_clr    (w_clr),
      .i_inc    (w_inc),
      .o_cnt    (w_cnt),
      .o_term_c (w_term)
   );

   // Ready in IDLE, or on the final bit so frames can run back-to-back.
   assign o_READY  = (r_state == ST_IDLE) | ((r_state == ST_SHIFT) & w_term);
   assign w_accept = i_VALID & o_READY;

   // Next-state and next-output decode.
   always_comb begin
      w_state_nx  = r_state;
      w_sh_nx     = r_sh;
      w_d_nx      = o_D;
      w_svalid_nx = o_SVALID;
      w_done_nx   = 1'b0;
      w_clr       = 1'b0;
      w_inc       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_sh_nx     = i_DATA >> 1;
               w_d_nx      = i_DATA[0];
               w_svalid_nx = 1'b1;
               w_clr       = 1'b1;
               w_state_nx  = ST_SHIFT;
            end else begin
               w_d_nx      = IDLE_LEVEL;
               w_svalid_nx = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (w_cnt < LAST) begin
               w_d_nx  = r_sh[0];
               w_sh_nx = r_sh >> 1;
               w_inc   = 1'b1;
            end else begin
               w_done_nx = 1'b1;
               if (w_accept) begin
                  w_sh_nx     = i_DATA >> 1;
                  w_d_nx      = i_DATA[0];
                  w_svalid_nx = 1'b1;
                  w_clr       = 1'b1;
                  w_state_nx  = ST_SHIFT;
               end else begin
                  w_d_nx      = IDLE_LEVEL;
                  w_svalid_nx = 1'b0;
                  w_state_nx  = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nx  = ST_IDLE;
            w_d_nx      = IDLE_LEVEL;
            w_svalid_nx = 1'b0;
         end
      endcase
   end

   // State, shift register and registered outputs; reset aborts any frame.
   always_ff @(posedge i_CLK) begin
      if (!i_RSTn) begin
         r_state  <= ST_IDLE;
         r_sh     <= '0;
         o_D      <= IDLE_LEVEL;
         o_SVALID <= 1'b0;
         o_BUSY   <= 1'b0;
         o_DONE   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_sh     <= w_sh_nx;
         o_D      <= w_d_nx;
         o_SVALID <= w_svalid_nx;
         o_BUSY   <= (w_state_nx == ST_SHIFT);
         o_DONE   <= w_done_nx;
      end
   end

endmodule

// File: tb/tb_bits4_serializer.sv
// Directed bench: three serializer instances with a bit scoreboard and capture-register model.
module tb_bits4_serializer;

   logic       clk;
   logic       rstn;

   logic [3:0] da;
   logic       va, a_rdy, a_d, a_sv, a_busy, a_done;
   logic [3:0] db;
   logic       vb, b_rdy, b_d, b_sv, b_busy, b_done;
   logic [7:0] dc;
   logic       vc, c_rdy, c_d, c_sv, c_busy, c_done;

   logic [3:0] cap_a;
   logic       qa[$];
   logic       qb[$];
   logic       qc[$];
   int         total;
   int         bad;
   int         npulse;
   logic       e;

   bits4_serializer #(.WIDTH(4), .IDLE_LEVEL(1'b0)) u_a (
      .i_CLK(clk), .i_RSTn(rstn), .i_DATA(da), .i_VALID(va), .o_READY(a_rdy),
      .o_D(a_d), .o_SVALID(a_sv), .o_BUSY(a_busy), .o_DONE(a_done));

   bits4_serializer #(.WIDTH(4), .IDLE_LEVEL(1'b1)) u_b (
      .i_CLK(clk), .i_RSTn(rstn), .i_DATA(db), .i_VALID(vb), .o_READY(b_rdy),
      .o_D(b_d), .o_SVALID(b_sv), .o_BUSY(b_busy), .o_DONE(b_done));

   bits4_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) u_c (
      .i_CLK(clk), .i_RSTn(rstn), .i_DATA(dc), .i_VALID(vc), .o_READY(c_rdy),
      .o_D(c_d), .o_SVALID(c_sv), .o_BUSY(c_busy), .o_DONE(c_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 4-bit serial-in/parallel-out capture register on the far end of link A.
   always_ff @(posedge clk) cap_a <= {a_d, cap_a[3:1]};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_a(input logic [3:0] w);
      for (int i = 0; i < 4; i++) qa.push_back(w[i]);
   endtask

   task automatic push_b(input logic [3:0] w);
      for (int i = 0; i < 4; i++) qb.push_back(w[i]);
   endtask

   task automatic push_c(input logic [7:0] w);
      for (int i = 0; i < 8; i++) qc.push_back(w[i]);
   endtask

   // Advance one clock and check every link's serial line against its scoreboard.
   task automatic tick();
      @(posedge clk);
      #1;
      if (a_sv) begin
         if (qa.size() == 0) chk("a_extra_bit", 32'(a_d), 32'h2);
         else begin e = qa.pop_front(); chk("a_bit", 32'(a_d), 32'(e)); end
      end else chk("a_idle_line", 32'(a_d), 32'h0);
      if (b_sv) begin
         if (qb.size() == 0) chk("b_extra_bit", 32'(b_d), 32'h2);
         else begin e = qb.pop_front(); chk("b_bit", 32'(b_d), 32'(e)); end
      end else chk("b_idle_line", 32'(b_d), 32'h1);
      if (c_sv) begin
         if (qc.size() == 0) chk("c_extra_bit", 32'(c_d), 32'h2);
         else begin e = qc.pop_front(); chk("c_bit", 32'(c_d), 32'(e)); end
      end else chk("c_idle_line", 32'(c_d), 32'h0);
   endtask

   initial begin
      total = 0; bad = 0;
      rstn = 1'b0;
      da = '0; va = 1'b0; db = '0; vb = 1'b0; dc = '0; vc = 1'b0;
      tick(); tick();
      chk("rst_sv", 32'(a_sv), 32'h0);
      chk("rst_busy", 32'(a_busy), 32'h0);
      chk("rst_done", 32'(a_done), 32'h0);
      chk("rst_rdy", 32'(a_rdy), 32'h1);
      chk("rst_b_d", 32'(b_d), 32'h1);
      rstn = 1'b1;
      tick();

      // IDLE_LEVEL=1 instance idles high and stays ready.
      for (int i = 0; i < 10; i++) begin
         chk("b_idle_rdy", 32'(b_rdy), 32'h1);
         tick();
      end
      db = 4'h0; vb = 1'b1; push_b(4'h0);
      tick();
      vb = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      tick();
      chk("b_done", 32'(b_done), 32'h1);
      chk("b_line_back_high", 32'(b_d), 32'h1);

      // Single word 1011 on link A.
      da = 4'b1011; va = 1'b1; push_a(4'b1011);
      tick();
      va = 1'b0; da = 4'h0;
      chk("t1_busy", 32'(a_busy), 32'h1);
      chk("t1_rdy", 32'(a_rdy), 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("t1_sv", 32'(a_sv), 32'h1);
         chk("t1_no_done", 32'(a_done), 32'h0);
         tick();
      end
      tick();
      chk("t1_done", 32'(a_done), 32'h1);
      chk("t1_sv_low", 32'(a_sv), 32'h0);
      chk("t1_cap", 32'(cap_a), 32'hB);
      chk("t1_q_empty", 32'(qa.size()), 32'h0);
      tick();
      chk("t1_done_pulse", 32'(a_done), 32'h0);

      // Back-to-back A then 5 with valid held.
      da = 4'hA; va = 1'b1; push_a(4'hA);
      chk("t2_rdy_e0", 32'(a_rdy), 32'h1);
      tick();
      da = 4'h5; push_a(4'h5);
      for (int i = 0; i < 3; i++) begin
         chk("t2_rdy_low", 32'(a_rdy), 32'h0);
         chk("t2_no_done", 32'(a_done), 32'h0);
         tick();
      end
      chk("t2_rdy_e4", 32'(a_rdy), 32'h1);
      tick();
      va = 1'b0;
      chk("t2_done1", 32'(a_done), 32'h1);
      chk("t2_sv_cont", 32'(a_sv), 32'h1);
      chk("t2_cap1", 32'(cap_a), 32'hA);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_sv_high", 32'(a_sv), 32'h1);
         chk("t2_no_done2", 32'(a_done), 32'h0);
      end
      tick();
      chk("t2_done2", 32'(a_done), 32'h1);
      chk("t2_cap2", 32'(cap_a), 32'h5);

      // Valid with F during a frame is ignored until the final edge.
      da = 4'h2; va = 1'b1; push_a(4'h2);
      tick();
      va = 1'b0;
      tick();
      da = 4'hF; va = 1'b1; push_a(4'hF);
      chk("t3_rdy_cnt1", 32'(a_rdy), 32'h0);
      tick();
      tick();
      chk("t3_rdy_last", 32'(a_rdy), 32'h1);
      tick();
      va = 1'b0;
      chk("t3_done1", 32'(a_done), 32'h1);
      chk("t3_cap1", 32'(cap_a), 32'h2);
      for (int i = 0; i < 3; i++) tick();
      tick();
      chk("t3_done2", 32'(a_done), 32'h1);
      chk("t3_cap2", 32'(cap_a), 32'hF);

      // Reset mid-frame aborts without done.
      da = 4'h9; va = 1'b1; qa.push_back(1'b1); qa.push_back(1'b0);
      tick();
      va = 1'b0;
      tick();
      rstn = 1'b0;
      tick();
      chk("t4_sv", 32'(a_sv), 32'h0);
      chk("t4_busy", 32'(a_busy), 32'h0);
      chk("t4_done", 32'(a_done), 32'h0);
      chk("t4_d", 32'(a_d), 32'h0);
      chk("t4_rdy", 32'(a_rdy), 32'h1);
      rstn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t4_no_done", 32'(a_done), 32'h0);
      end
      da = 4'h6; va = 1'b1; push_a(4'h6);
      tick();
      va = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      tick();
      chk("t4_done_new", 32'(a_done), 32'h1);
      chk("t4_cap", 32'(cap_a), 32'h6);

      // WIDTH=8 instance, word C3.
      dc = 8'hC3; vc = 1'b1; push_c(8'hC3);
      tick();
      vc = 1'b0;
      npulse = 0;
      for (int i = 1; i <= 11; i++) begin
         if (i > 1) tick();
         else tick();
         if (c_done) npulse++;
         chk("c_done_at", 32'(c_done), (i == 8) ? 32'h1 : 32'h0);
      end
      chk("c_done_count", 32'(npulse), 32'h1);

      chk("qa_drained", 32'(qa.size()), 32'h0);
      chk("qb_drained", 32'(qb.size()), 32'h0);
      chk("qc_drained", 32'(qc.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
